// File: rtl/cpu_pkg.sv
// Shared constants and the IF/ID payload type for the pipelined MIPS core.
package cpu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [XLEN-1:0] RESET_PC   = 32'h8000_0000;
    localparam logic [XLEN-1:0] IRQ_VECTOR = 32'h8000_0004;
    localparam logic [XLEN-1:0] EXC_VECTOR = 32'h8000_0008;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    localparam logic [XLEN-1:0] MODE_MASK = 32'h8000_0000;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc_plus4;
        logic              valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{inst: NOP_INST, pc_plus4: '0, valid: 1'b0};

    // Branch/jump targets cannot change the supervisor bit; it is taken from the current pc.
    function automatic logic [XLEN-1:0] keep_mode(input logic [XLEN-1:0] target,
                                                  input logic [XLEN-1:0] pc);
        return (target & ~MODE_MASK) | (pc & MODE_MASK);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: ROM port, hazard/redirect controls and the IF/ID outputs.
interface fetch_stage_if;
    import cpu_pkg::*;

    logic [XLEN-1:0]   imem_addr;
    logic [INST_W-1:0] imem_data;
    logic              stall;
    logic              flush;
    logic              br_taken;
    logic [XLEN-1:0]   br_target;
    logic              jmp;
    logic [XLEN-1:0]   jmp_target;
    logic              jr;
    logic [XLEN-1:0]   jr_target;
    logic              exc;
    logic              irq_req;
    logic              irq_ack;
    logic [XLEN-1:0]   epc;
    logic [INST_W-1:0] id_inst;
    logic [XLEN-1:0]   id_pc_plus4;
    logic              id_valid;

    modport master (
        output imem_addr, irq_ack, epc, id_inst, id_pc_plus4, id_valid,
        input  imem_data, stall, flush, br_taken, br_target, jmp, jmp_target,
               jr, jr_target, exc, irq_req
    );

    modport slave (
        input  imem_addr, irq_ack, epc, id_inst, id_pc_plus4, id_valid,
        output imem_data, stall, flush, br_taken, br_target, jmp, jmp_target,
               jr, jr_target, exc, irq_req
    );

endinterface

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: exc > branch > jr > jmp > irq > stall hold > sequential.
module next_pc_sel
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic            exc_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            jr_i,
    input  logic [XLEN-1:0] jr_target_i,
    input  logic            jmp_i,
    input  logic [XLEN-1:0] jmp_target_i,
    input  logic            irq_take_i,
    input  logic            stall_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            redirect_o
);

    always_comb begin
        next_pc_o  = pc_plus4_i;
        redirect_o = 1'b1;
        if (exc_i) begin
            next_pc_o = EXC_VECTOR;
        end else if (br_taken_i) begin
            next_pc_o = keep_mode(br_target_i, pc_i);
        end else if (jr_i) begin
            next_pc_o = jr_target_i;
        end else if (jmp_i) begin
            next_pc_o = keep_mode(jmp_target_i, pc_i);
        end else if (irq_take_i) begin
            next_pc_o = IRQ_VECTOR;
        end else if (stall_i) begin
            next_pc_o  = pc_i;
            redirect_o = 1'b0;
        end else begin
            redirect_o = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, addresses the ROM and fills the IF/ID register.
module fetch_stage
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    ifid_t           ifid_q, ifid_d;
    logic [XLEN-1:0] pc_plus4;
    logic            irq_take_c;
    logic            redirect;

    // Sequential increment wraps inside the low 31 bits; the mode bit is sticky.
    assign pc_plus4 = {pc_q[XLEN-1], pc_q[XLEN-2:0] + (XLEN-1)'(4)};

    // Interrupts are only taken from user mode on an otherwise quiet cycle.
    assign irq_take_c = bus.irq_req & ~pc_q[XLEN-1] & ~bus.exc & ~bus.br_taken &
                        ~bus.jr & ~bus.jmp & ~bus.stall & ~bus.flush;

    next_pc_sel u_next_pc_sel (
        .pc_i         (pc_q),
        .pc_plus4_i   (pc_plus4),
        .exc_i        (bus.exc),
        .br_taken_i   (bus.br_taken),
        .br_target_i  (bus.br_target),
        .jr_i         (bus.jr),
        .jr_target_i  (bus.jr_target),
        .jmp_i        (bus.jmp),
        .jmp_target_i (bus.jmp_target),
        .irq_take_i   (irq_take_c),
        .stall_i      (bus.stall),
        .next_pc_o    (pc_d),
        .redirect_o   (redirect)
    );

    always_comb begin
        ifid_d = ifid_q;
        epc_d  = epc_q;
        if (redirect || bus.flush) begin
            ifid_d = IFID_BUBBLE;
        end else if (!bus.stall) begin
            ifid_d = '{inst: bus.imem_data, pc_plus4: pc_plus4, valid: 1'b1};
        end
        if (bus.exc) begin
            epc_d = ifid_q.pc_plus4;
        end else if (irq_take_c) begin
            epc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= RESET_PC;
            epc_q  <= '0;
            ifid_q <= IFID_BUBBLE;
        end else begin
            pc_q   <= pc_d;
            epc_q  <= epc_d;
            ifid_q <= ifid_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.irq_ack     = irq_take_c;
    assign bus.epc         = epc_q;
    assign bus.id_inst     = ifid_q.inst;
    assign bus.id_pc_plus4 = ifid_q.pc_plus4;
    assign bus.id_valid    = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, stall, redirects, interrupts, exceptions.
module tb_fetch_stage;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0800_0003;
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus.imem_data = rom_word(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        bus.stall = 0; bus.flush = 0; bus.br_taken = 0; bus.jmp = 0;
        bus.jr = 0; bus.exc = 0; bus.irq_req = 0;
        bus.br_target = '0; bus.jmp_target = '0; bus.jr_target = '0;
    endtask

    task automatic go_to(input logic [31:0] target);
        bus.jr = 1; bus.jr_target = target;
        step();
        bus.jr = 0; bus.jr_target = '0;
    endtask

    task automatic test_reset();
        clear_ctl();
        bus.irq_req = 1;
        reset = 0;
        #12;
        checks++; if (bus.imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc got %h exp 80000000", bus.imem_addr); end
        checks++; if ({bus.id_inst, bus.id_pc_plus4, bus.id_valid} !== 65'h0) begin errors++; $display("FAIL reset_ifid got %h %h %b exp 0 0 0", bus.id_inst, bus.id_pc_plus4, bus.id_valid); end
        checks++; if (bus.epc !== 32'h0) begin errors++; $display("FAIL reset_epc got %h exp 0", bus.epc); end
        checks++; if (bus.irq_ack !== 1'b0) begin errors++; $display("FAIL reset_irq_ack got %b exp 0", bus.irq_ack); end
        bus.irq_req = 0;
        @(negedge clk);
        reset = 1;
        #1;
        checks++; if (bus.imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL release_pc got %h exp 80000000", bus.imem_addr); end
        step();
        checks++; if (bus.imem_addr !== 32'h8000_0004) begin errors++; $display("FAIL first_seq_pc got %h exp 80000004", bus.imem_addr); end
        checks++; if (bus.id_inst !== 32'h0800_0003 || bus.id_pc_plus4 !== 32'h8000_0004 || bus.id_valid !== 1'b1) begin
            errors++; $display("FAIL first_fetch got %h %h %b exp 08000003 80000004 1", bus.id_inst, bus.id_pc_plus4, bus.id_valid); end
    endtask

    task automatic test_stall();
        go_to(32'h0000_000C);
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL jr_bubble got %b exp 0", bus.id_valid); end
        step();
        checks++; if (bus.imem_addr !== 32'h0000_0010) begin errors++; $display("FAIL pre_stall_pc got %h exp 00000010", bus.imem_addr); end
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.imem_addr !== 32'h0000_0010 || bus.id_inst !== 32'hC0DE_000C ||
                          bus.id_pc_plus4 !== 32'h0000_0010 || bus.id_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold%0d got %h %h %h %b exp 00000010 c0de000c 00000010 1",
                                   i, bus.imem_addr, bus.id_inst, bus.id_pc_plus4, bus.id_valid); end
        end
        bus.stall = 0;
        step();
        checks++; if (bus.imem_addr !== 32'h0000_0014 || bus.id_inst !== 32'hC0DE_0010 || bus.id_pc_plus4 !== 32'h0000_0014) begin
            errors++; $display("FAIL stall_resume got %h %h %h exp 00000014 c0de0010 00000014", bus.imem_addr, bus.id_inst, bus.id_pc_plus4); end
    endtask

    task automatic test_jump();
        for (int s = 0; s < 2; s++) begin
            go_to(32'h8000_0020);
            step();
            bus.stall = (s == 1); bus.jmp = 1; bus.jmp_target = 32'h0000_0038;
            step();
            bus.stall = 0; bus.jmp = 0;
            checks++; if (bus.imem_addr !== 32'h8000_0038) begin errors++; $display("FAIL jmp_pc_stall%0d got %h exp 80000038", s, bus.imem_addr); end
            checks++; if ({bus.id_inst, bus.id_pc_plus4, bus.id_valid} !== 65'h0) begin errors++; $display("FAIL jmp_bubble_stall%0d got %h %h %b exp 0 0 0", s, bus.id_inst, bus.id_pc_plus4, bus.id_valid); end
        end
    endtask

    task automatic test_br_jmp();
        go_to(32'h0000_0100);
        bus.br_taken = 1; bus.br_target = 32'h0000_0040; bus.jmp = 1; bus.jmp_target = 32'h0000_0080;
        step();
        bus.br_taken = 0; bus.jmp = 0;
        checks++; if (bus.imem_addr !== 32'h0000_0040) begin errors++; $display("FAIL br_over_jmp got %h exp 00000040", bus.imem_addr); end
        // Branch target with bit 31 set must not promote a user pc to kernel.
        bus.br_taken = 1; bus.br_target = 32'h8000_0050;
        step();
        bus.br_taken = 0;
        checks++; if (bus.imem_addr !== 32'h0000_0050) begin errors++; $display("FAIL br_keep_mode got %h exp 00000050", bus.imem_addr); end
        go_to(32'h7FFF_FFFC);
        step();
        checks++; if (bus.imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_user got %h exp 00000000", bus.imem_addr); end
        go_to(32'hFFFF_FFFC);
        step();
        checks++; if (bus.imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL wrap_kernel got %h exp 80000000", bus.imem_addr); end
    endtask

    task automatic test_irq();
        go_to(32'h0000_0060);
        bus.irq_req = 1; bus.stall = 1;
        #1;
        checks++; if (bus.irq_ack !== 1'b0) begin errors++; $display("FAIL irq_blocked_by_stall got %b exp 0", bus.irq_ack); end
        step();
        bus.stall = 0;
        #1;
        checks++; if (bus.irq_ack !== 1'b1) begin errors++; $display("FAIL irq_ack_pulse got %b exp 1", bus.irq_ack); end
        step();
        checks++; if (bus.imem_addr !== 32'h8000_0004 || bus.epc !== 32'h0000_0064) begin
            errors++; $display("FAIL irq_entry got pc %h epc %h exp 80000004 00000064", bus.imem_addr, bus.epc); end
        checks++; if (bus.irq_ack !== 1'b0 || bus.id_valid !== 1'b0) begin
            errors++; $display("FAIL irq_after got ack %b valid %b exp 0 0", bus.irq_ack, bus.id_valid); end
        go_to(32'h8000_0100);
        #1;
        checks++; if (bus.irq_ack !== 1'b0) begin errors++; $display("FAIL irq_kernel_ack got %b exp 0", bus.irq_ack); end
        step();
        checks++; if (bus.imem_addr !== 32'h8000_0104 || bus.epc !== 32'h0000_0064) begin
            errors++; $display("FAIL irq_kernel_ignored got pc %h epc %h exp 80000104 00000064", bus.imem_addr, bus.epc); end
        bus.irq_req = 0;
        go_to(32'h0000_0060);
        checks++; if (bus.imem_addr !== 32'h0000_0060) begin errors++; $display("FAIL jr_user got %h exp 00000060", bus.imem_addr); end
    endtask

    task automatic test_exc();
        for (int k = 0; k < 2; k++) begin
            go_to(32'h0000_0044);
            step();
            checks++; if (bus.id_pc_plus4 !== 32'h0000_0048) begin errors++; $display("FAIL exc_setup%0d got %h exp 00000048", k, bus.id_pc_plus4); end
            bus.exc = 1; bus.irq_req = (k == 1);
            #1;
            checks++; if (bus.irq_ack !== 1'b0) begin errors++; $display("FAIL exc_irq_ack%0d got %b exp 0", k, bus.irq_ack); end
            step();
            bus.exc = 0; bus.irq_req = 0;
            checks++; if (bus.imem_addr !== 32'h8000_0008 || bus.epc !== 32'h0000_0048 || bus.id_valid !== 1'b0) begin
                errors++; $display("FAIL exc_entry%0d got pc %h epc %h valid %b exp 80000008 00000048 0",
                                   k, bus.imem_addr, bus.epc, bus.id_valid); end
        end
    endtask

    task automatic test_flush_and_midreset();
        go_to(32'h0000_0200);
        step();
        bus.flush = 1;
        step();
        bus.flush = 0;
        checks++; if (bus.imem_addr !== 32'h0000_0208 || bus.id_valid !== 1'b0) begin
            errors++; $display("FAIL flush got pc %h valid %b exp 00000208 0", bus.imem_addr, bus.id_valid); end
        #2;
        reset = 0;
        #1;
        checks++; if (bus.imem_addr !== 32'h8000_0000 || bus.epc !== 32'h0 || bus.id_valid !== 1'b0 || bus.id_inst !== 32'h0) begin
            errors++; $display("FAIL midreset got pc %h epc %h valid %b inst %h exp 80000000 0 0 0",
                               bus.imem_addr, bus.epc, bus.id_valid, bus.id_inst); end
        @(negedge clk);
        reset = 1;
        step();
        checks++; if (bus.imem_addr !== 32'h8000_0004) begin errors++; $display("FAIL midreset_release got %h exp 80000004", bus.imem_addr); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_stall();
        test_jump();
        test_br_jmp();
        test_irq();
        test_exc();
        test_flush_and_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. Owns the program counter, drives the combinational instruction ROM address, and registers the returned word into the IF/ID pipeline register. Arbitrates next-PC between sequential, branch, jump, jump-register, interrupt and exception redirects. Maintains the PC[31] supervisor bit across user/kernel transitions.

## Interface
- RESET_PC, 32'h8000_0000, PC after reset (kernel mode, ROM word 0)
- IRQ_VECTOR, 32'h8000_0004, interrupt entry
- EXC_VECTOR, 32'h8000_0008, exception entry
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_addr  out  32  ROM byte address; combinational copy of pc
- imem_data  in  32  ROM word for imem_addr, same cycle; 0 (nop) out of range
- stall  in  1  hazard unit: hold pc and IF/ID
- flush  in  1  load bubble into IF/ID
- br_taken  in  1  EX-stage branch taken; br_target  in  32
- jmp  in  1  ID-stage j/jal; jmp_target  in  32
- jr  in  1  ID-stage jr/jalr; jr_target  in  32
- exc  in  1  ID-stage undefined instruction
- irq_req  in  1  level interrupt request from timer
- irq_ack  out  1  one-cycle pulse: interrupt taken
- epc  out  32  return value for $26 ($k0), valid the cycle irq_ack or exc takes effect and held after
- id_inst  out  32  IF/ID instruction
- id_pc_plus4  out  32  IF/ID PC+4
- id_valid  out  1  IF/ID holds a real instruction

## Operation
- pc_plus4 = {pc[31], pc[30:0] + 31'd4}; bit 31 never changes on sequential fetch; wraps within the 31-bit field.
- Next-PC priority: exc > br_taken > jr > jmp > irq > stall(hold) > pc_plus4.
- Branch and jump targets: bit 31 replaced by current pc[31]. jr target used as full 32 bits (only way to leave kernel mode).
- Exception: pc <= EXC_VECTOR; epc <= id_pc_plus4.
- Interrupt: taken only when irq_req=1, pc[31]=0, and exc, br_taken, jr, jmp, stall, flush all 0. Then pc <= IRQ_VECTOR, epc <= pc_plus4 (handler subtracts 4 and re-fetches the discarded instruction), irq_ack=1 for that cycle. Otherwise request remains pending (level), no internal latch.
- IF/ID update: any redirect (exc, br_taken, jr, jmp, irq taken) or flush loads bubble {32'h0, 32'h0, 0}; else if stall holds; else loads {imem_data, pc_plus4, 1}.
- Redirect during stall: redirect wins; pc updates, IF/ID gets bubble.
- Outputs registered except imem_addr and irq_ack (combinational decode of the take condition).

## Timing
- Reset (async, reset=0): pc=RESET_PC, id_inst=0, id_pc_plus4=0, id_valid=0, epc=0; irq_ack=0 while in reset. Release: first fetch from RESET_PC in the cycle after deassertion is sampled.
- Fetch latency: word at pc appears on id_inst one edge later.
- Redirect latency: target on imem_addr the cycle after the redirect input is high.
- Reset mid-operation forces all state to reset values immediately, regardless of clk.

## Structure
- Shared package cpu_pkg: RESET_PC, IRQ_VECTOR, EXC_VECTOR, NOP_INST (32'h0), IF/ID bundle field widths.
- One sub-module: next_pc_sel (combinational priority mux plus bit-31 handling); PC and IF/ID registers stay in fetch_stage.

## Test plan
- Reset release, ROM word0=32'h08000003 -> imem_addr 0x80000000, then 0x80000004; id_inst=32'h08000003, id_pc_plus4=0x80000004, id_valid=1.
- stall=1 for 3 cycles at pc=0x00000010 -> pc and IF/ID unchanged; resume -> 0x00000014.
- jmp=1, jmp_target=0x0000_0038 while pc=0x8000_0020 -> next pc=0x8000_0038, IF/ID bubble; same with stall=1 -> identical result.
- br_taken and jmp same cycle (br_target=0x40, jmp_target=0x80, pc[31]=0) -> pc=0x40.
- irq_req=1 at user pc=0x00000060 -> irq_ack pulse, pc=0x80000004, epc=0x00000064; irq_req=1 at pc=0x80000100 -> ignored; jr to 0x00000060 -> pc=0x00000060, bit31 cleared.
- exc=1 with id_pc_plus4=0x0000_0048 -> pc=0x80000008, epc=0x0000_0048; exc and irq together -> exception only, no irq_ack.
